// File: rtl/uart_mmio_buffer.sv
// Memory-mapped UART buffer: a TX FIFO fed by CPU stores and drained by the serial
// transmitter, plus an RX FIFO fed by the serial receiver and drained by CPU loads.
module uart_mmio_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        REUART,
  input  logic        WEUART,
  input  logic [1:0]  UARTsel,
  input  logic [7:0]  DataIn,
  output logic [31:0] ReadData,
  output logic [7:0]  SerTxData,
  output logic        SerTxValid,
  input  logic        SerTxReady,
  input  logic [7:0]  SerRxData,
  input  logic        SerRxValid,
  output logic        SerRxReady,
  output logic        TxOverflow,
  output logic        RxOverflow
);

  localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

  logic [7:0]    tx_mem_q [DEPTH];
  logic [7:0]    rx_mem_q [DEPTH];
  logic [AW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [AW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [AW:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic          tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;
  logic          tx_push_s, tx_pop_s, rx_push_s, rx_pop_s;

  // A same-edge pop frees the slot a push into a full TX FIFO needs.
  assign tx_pop_s  = (tx_cnt_q != '0) && SerTxReady;
  assign tx_push_s = WEUART && ((tx_cnt_q < DEPTH_C) || tx_pop_s);
  assign rx_push_s = SerRxValid && (rx_cnt_q < DEPTH_C);
  assign rx_pop_s  = REUART && (rx_cnt_q != '0);

  // Next-state for pointers, counts and sticky flags.
  always_comb begin
    tx_wptr_d = tx_wptr_q;
    tx_rptr_d = tx_rptr_q;
    tx_cnt_d  = tx_cnt_q;
    rx_wptr_d = rx_wptr_q;
    rx_rptr_d = rx_rptr_q;
    rx_cnt_d  = rx_cnt_q;
    tx_ovf_d  = tx_ovf_q;
    rx_ovf_d  = rx_ovf_q;

    if (tx_push_s) tx_wptr_d = tx_wptr_q + PTR_ONE;
    else           tx_wptr_d = tx_wptr_q;
    if (tx_pop_s)  tx_rptr_d = tx_rptr_q + PTR_ONE;
    else           tx_rptr_d = tx_rptr_q;
    if (rx_push_s) rx_wptr_d = rx_wptr_q + PTR_ONE;
    else           rx_wptr_d = rx_wptr_q;
    if (rx_pop_s)  rx_rptr_d = rx_rptr_q + PTR_ONE;
    else           rx_rptr_d = rx_rptr_q;

    case ({tx_push_s, tx_pop_s})
      2'b10:   tx_cnt_d = tx_cnt_q + CNT_ONE;
      2'b01:   tx_cnt_d = tx_cnt_q - CNT_ONE;
      default: tx_cnt_d = tx_cnt_q;
    endcase
    case ({rx_push_s, rx_pop_s})
      2'b10:   rx_cnt_d = rx_cnt_q + CNT_ONE;
      2'b01:   rx_cnt_d = rx_cnt_q - CNT_ONE;
      default: rx_cnt_d = rx_cnt_q;
    endcase

    if (WEUART && !tx_push_s) tx_ovf_d = 1'b1;
    else                      tx_ovf_d = tx_ovf_q;
  end

  // Control state with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
      tx_ovf_q  <= 1'b0;
      rx_ovf_q  <= 1'b0;
    end else begin
      tx_wptr_q <= tx_wptr_d;
      tx_rptr_q <= tx_rptr_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_wptr_q <= rx_wptr_d;
      rx_rptr_q <= rx_rptr_d;
      rx_cnt_q  <= rx_cnt_d;
      tx_ovf_q  <= tx_ovf_d;
      rx_ovf_q  <= rx_ovf_d;
    end
  end

  // Entry storage is not reset; contents are only meaningful below the count.
  always_ff @(posedge clk) begin
    if (tx_push_s) tx_mem_q[tx_wptr_q] <= DataIn;
    if (rx_push_s) rx_mem_q[rx_wptr_q] <= SerRxData;
  end

  assign SerTxValid = (tx_cnt_q != '0);
  assign SerTxData  = tx_mem_q[tx_rptr_q];
  assign SerRxReady = (rx_cnt_q < DEPTH_C);
  assign TxOverflow = tx_ovf_q;
  assign RxOverflow = rx_ovf_q;

  // CPU load mux, driven from the pre-edge state.
  always_comb begin
    ReadData = 32'h0000_0000;
    case (UARTsel)
      2'b00: begin
        if (rx_cnt_q != '0) ReadData = {24'h00_0000, rx_mem_q[rx_rptr_q]};
        else                ReadData = 32'h0000_0000;
      end
      2'b01:   ReadData = {31'h0000_0000, (tx_cnt_q < DEPTH_C)};
      2'b10:   ReadData = {31'h0000_0000, (rx_cnt_q != '0)};
      default: ReadData = 32'h0000_0000;
    endcase
  end

endmodule
